// File: rtl/accel_seq_fsm.sv
// Command sequencer for one accelerator: key read, text read, accelerator op and
// result write over the shared bus, then a {err, dest_addr} completion post.
module accel_seq_fsm #(
  parameter int unsigned ADDRW     = 24,
  parameter logic [1:0]  ACCEL_ID  = 2'b01,
  parameter logic [1:0]  MEM_ID    = 2'b00,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [3*ADDRW+1:0] req_data,
  output logic               ready_req_out,
  input  logic               compq_ready_in,
  output logic [ADDRW:0]     compq_data_out,
  output logic               valid_compq_out,
  output logic               arb_req,
  input  logic               arb_grant,
  input  logic [2:0]         ack_in,
  output logic [ADDRW+7:0]   data_out,
  output logic               busy
);

  // key_mode only steers the IDLE branch, so it is not kept in the latched request
  localparam int unsigned LATW = 3*ADDRW+1;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    RDKEY      = 4'd1,
    WAIT_RDKEY = 4'd2,
    RDTEXT     = 4'd3,
    WAIT_RDTXT = 4'd4,
    OP         = 4'd5,
    WAIT_OP    = 4'd6,
    MEMWR      = 4'd7,
    WAIT_MEMWR = 4'd8,
    COMPLETE   = 4'd9
  } state_t;

  state_t               state_q, state_d;
  logic [LATW-1:0]      req_q, req_d;
  logic                 err_q, err_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] cnt_inc;

  logic                 op_flag;
  logic [ADDRW-1:0]     key_addr;
  logic [ADDRW-1:0]     src_addr;
  logic [ADDRW-1:0]     dest_addr;
  logic                 mem_ack;
  logic                 accel_ack;
  logic                 expire;
  logic [ADDRW+7:0]     rdkey_word;
  logic [ADDRW+7:0]     rdtext_word;
  logic [ADDRW+7:0]     op_word;
  logic [ADDRW+7:0]     memwr_word;

  assign op_flag   = req_q[LATW-1];
  assign key_addr  = req_q[3*ADDRW-1:2*ADDRW];
  assign src_addr  = req_q[2*ADDRW-1:ADDRW];
  assign dest_addr = req_q[ADDRW-1:0];

  assign mem_ack   = (ack_in == {1'b1, MEM_ID});
  assign accel_ack = (ack_in == {1'b1, ACCEL_ID});

  // The wait expires in the cycle whose miss would bring the counter to all-ones
  assign cnt_inc = cnt_q + TIMEOUT_W'(1);
  assign expire  = &cnt_inc;

  assign rdkey_word  = {key_addr, 2'b01, ACCEL_ID, MEM_ID, 2'b01};
  assign rdtext_word = {src_addr, 2'b00, ACCEL_ID, MEM_ID, 2'b01};
  assign op_word     = {{ADDRW{1'b0}}, op_flag, 1'b0, ACCEL_ID, 4'b0011};
  assign memwr_word  = {dest_addr, 2'b00, MEM_ID, ACCEL_ID, 2'b10};

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    err_d           = err_q;
    cnt_d           = cnt_q;
    ready_req_out   = 1'b0;
    valid_compq_out = 1'b0;
    compq_data_out  = '0;
    arb_req         = 1'b0;
    data_out        = '0;

    case (state_q)
      IDLE: begin
        ready_req_out = 1'b1;
        if (req_valid) begin
          req_d   = req_data[LATW-1:0];
          err_d   = 1'b0;
          state_d = req_data[3*ADDRW+1] ? RDKEY : RDTEXT;
        end
      end

      RDKEY: begin
        arb_req  = 1'b1;
        data_out = rdkey_word;
        if (arb_grant) begin
          cnt_d   = '0;
          state_d = WAIT_RDKEY;
        end
      end

      WAIT_RDKEY: begin
        data_out = rdkey_word;
        if (mem_ack) begin
          state_d = RDTEXT;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RDTEXT: begin
        arb_req  = 1'b1;
        data_out = rdtext_word;
        if (arb_grant) begin
          cnt_d   = '0;
          state_d = WAIT_RDTXT;
        end
      end

      WAIT_RDTXT: begin
        data_out = rdtext_word;
        if (mem_ack) begin
          state_d = OP;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      OP: begin
        arb_req  = 1'b1;
        data_out = op_word;
        if (arb_grant) begin
          cnt_d   = '0;
          state_d = WAIT_OP;
        end
      end

      WAIT_OP: begin
        data_out = op_word;
        if (accel_ack) begin
          state_d = MEMWR;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      MEMWR: begin
        arb_req  = 1'b1;
        data_out = memwr_word;
        if (arb_grant) begin
          cnt_d   = '0;
          state_d = WAIT_MEMWR;
        end
      end

      WAIT_MEMWR: begin
        data_out = memwr_word;
        if (mem_ack) begin
          state_d = COMPLETE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      COMPLETE: begin
        valid_compq_out = 1'b1;
        compq_data_out  = {err_q, dest_addr};
        if (compq_ready_in) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_accel_seq_fsm.sv
// Randomised bench for accel_seq_fsm: a phase-level model predicts command words,
// completion {err, dest} and accept-to-COMPLETE latency for each request.
module tb_accel_seq_fsm;

  localparam int          AW    = 24;
  localparam int          TW    = 4;
  localparam int          TMO   = (1 << TW) - 1;
  localparam logic [1:0]  ACCEL = 2'b01;
  localparam logic [1:0]  MEM   = 2'b00;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic [3*AW+1:0] req_data = '0;
  logic            ready_req_out;
  logic            compq_ready_in = 1'b0;
  logic [AW:0]     compq_data_out;
  logic            valid_compq_out;
  logic            arb_req;
  logic            arb_grant = 1'b0;
  logic [2:0]      ack_in = 3'b000;
  logic [AW+7:0]   data_out;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  accel_seq_fsm #(
    .ADDRW(AW), .ACCEL_ID(ACCEL), .MEM_ID(MEM), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .ready_req_out(ready_req_out), .compq_ready_in(compq_ready_in),
    .compq_data_out(compq_data_out), .valid_compq_out(valid_compq_out),
    .arb_req(arb_req), .arb_grant(arb_grant), .ack_in(ack_in),
    .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // phase 0 = key read, 1 = text read, 2 = accelerator op, 3 = result write
  function automatic logic [31:0] exp_word(input int p, input logic opf,
                                           input logic [23:0] ka, sa, da);
    case (p)
      0:       return {ka, 2'b01, ACCEL, MEM, 2'b01};
      1:       return {sa, 2'b00, ACCEL, MEM, 2'b01};
      2:       return {24'h0, opf, 1'b0, ACCEL, 4'b0011};
      default: return {da, 2'b00, MEM, ACCEL, 2'b10};
    endcase
  endfunction

  function automatic logic [2:0] non_match(input logic [1:0] eid, input bit force_wrong);
    logic [2:0] r;
    if (force_wrong) return {1'b1, (eid == MEM) ? ACCEL : MEM};
    r = 3'($urandom);
    if (r[1:0] == eid) r[2] = 1'b0;
    return r;
  endfunction

  function automatic int model_latency(input logic km, input logic [3:0][4:0] gd,
                                       input logic [3:0][4:0] ad);
    int l = 1;
    for (int p = (km ? 0 : 1); p < 4; p++) begin
      l += int'(gd[p]) + 1;
      if (int'(ad[p]) >= TMO) begin
        l += TMO;
        break;
      end
      l += int'(ad[p]) + 1;
    end
    return l;
  endfunction

  function automatic logic model_err(input logic km, input logic [3:0][4:0] ad);
    for (int p = (km ? 0 : 1); p < 4; p++)
      if (int'(ad[p]) >= TMO) return 1'b1;
    return 1'b0;
  endfunction

  // Drives one request end to end; gd/ad give per-phase grant and ACK delays,
  // an ACK delay of TMO or more means the ACK never comes.
  task automatic run_request(input logic km, input logic opf,
                             input logic [23:0] ka, sa, da,
                             input logic [3:0][4:0] gd, input logic [3:0][4:0] ad,
                             input int hold, input bit force_wrong, input bit req_in_hold,
                             output int lat);
    logic [31:0] w;
    logic [1:0]  eid;
    logic        err;
    int          acc;
    err = 1'b0;
    checks++;
    if (ready_req_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_req_ready got=%0b exp=1", ready_req_out);
    end
    req_valid = 1'b1;
    req_data  = {km, opf, ka, sa, da};
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = {$urandom, $urandom, $urandom};
    checks++;
    if (ready_req_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dequeue ready=%0b busy=%0b exp ready=0 busy=1", ready_req_out, busy);
    end
    for (int p = (km ? 0 : 1); p < 4 && !err; p++) begin
      w   = exp_word(p, opf, ka, sa, da);
      eid = (p == 2) ? ACCEL : MEM;
      for (int g = 0; g <= int'(gd[p]); g++) begin
        checks++;
        if (arb_req !== 1'b1 || data_out !== w) begin
          errors++;
          $display("[TB] FAIL issue phase=%0d arb_req=%0b data=%08h exp arb_req=1 data=%08h",
                   p, arb_req, data_out, w);
        end
        arb_grant = (g == int'(gd[p]));
        ack_in    = 3'($urandom);
        @(negedge clk);
      end
      arb_grant = 1'b0;
      for (int c = 0; c < TMO; c++) begin
        checks++;
        if (arb_req !== 1'b0 || data_out !== w || valid_compq_out !== 1'b0) begin
          errors++;
          $display("[TB] FAIL wait phase=%0d c=%0d arb_req=%0b data=%08h valid=%0b exp 0/%08h/0",
                   p, c, arb_req, data_out, valid_compq_out, w);
        end
        arb_grant = 1'($urandom);
        ack_in    = (c == int'(ad[p])) ? {1'b1, eid} : non_match(eid, force_wrong);
        @(negedge clk);
        if (c == int'(ad[p])) break;
      end
      ack_in    = 3'b000;
      arb_grant = 1'b0;
      if (int'(ad[p]) >= TMO) err = 1'b1;
    end
    lat = cyc - acc;
    checks++;
    if (valid_compq_out !== 1'b1 || compq_data_out !== {err, da}) begin
      errors++;
      $display("[TB] FAIL completion valid=%0b data=%07h exp valid=1 data=%07h",
               valid_compq_out, compq_data_out, {err, da});
    end
    checks++;
    if (arb_req !== 1'b0 || data_out !== '0 || busy !== 1'b1 || ready_req_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL complete_outs arb_req=%0b data=%08h busy=%0b ready=%0b exp 0/0/1/0",
               arb_req, data_out, busy, ready_req_out);
    end
    for (int h = 0; h < hold; h++) begin
      compq_ready_in = 1'b0;
      req_valid      = req_in_hold;
      ack_in         = 3'($urandom);
      @(negedge clk);
      checks++;
      if (valid_compq_out !== 1'b1 || compq_data_out !== {err, da} || ready_req_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold h=%0d valid=%0b data=%07h ready=%0b exp 1/%07h/0",
                 h, valid_compq_out, compq_data_out, ready_req_out, {err, da});
      end
    end
    req_valid      = 1'b0;
    ack_in         = 3'b000;
    compq_ready_in = 1'b1;
    @(negedge clk);
    compq_ready_in = 1'b0;
    checks++;
    if (ready_req_out !== 1'b1 || valid_compq_out !== 1'b0 || busy !== 1'b0 || compq_data_out !== '0) begin
      errors++;
      $display("[TB] FAIL back_idle ready=%0b valid=%0b busy=%0b data=%07h exp 1/0/0/0",
               ready_req_out, valid_compq_out, busy, compq_data_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready_req_out !== 1'b1 || busy !== 1'b0 || arb_req !== 1'b0 || valid_compq_out !== 1'b0
        || data_out !== '0 || compq_data_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset ready=%0b busy=%0b arb=%0b valid=%0b data=%08h cq=%07h exp 1/0/0/0/0/0",
               ready_req_out, busy, arb_req, valid_compq_out, data_out, compq_data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_req_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset ready=%0b busy=%0b exp 1/0", ready_req_out, busy);
    end
  endtask

  task automatic test_min_no_key();
    logic [3:0][4:0] gd = '0;
    logic [3:0][4:0] ad = '0;
    int lat;
    run_request(1'b0, 1'b1, 24'h0, 24'h000100, 24'h000200, gd, ad, 0, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("[TB] FAIL latency_no_key got=%0d exp=7", lat);
    end
  endtask

  task automatic test_min_key();
    logic [3:0][4:0] gd = '0;
    logic [3:0][4:0] ad = '0;
    int lat;
    run_request(1'b1, 1'b0, 24'h000040, 24'h000100, 24'h000200, gd, ad, 0, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("[TB] FAIL latency_key got=%0d exp=9", lat);
    end
  endtask

  task automatic test_timeout_op();
    logic [3:0][4:0] gd = '0;
    logic [3:0][4:0] ad = '0;
    int lat;
    ad[2] = 5'd31;
    run_request(1'b0, 1'b1, 24'h0, 24'h000100, 24'h000300, gd, ad, 2, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 1 + 2 + 1 + 15) begin
      errors++;
      $display("[TB] FAIL timeout_latency got=%0d exp=19", lat);
    end
    // ACK landing in the very last wait cycle must beat the timeout
    ad[2] = 5'd14;
    run_request(1'b0, 1'b0, 24'h0, 24'h000111, 24'h000222, gd, ad, 0, 1'b0, 1'b0, lat);
  endtask

  task automatic test_wrong_id();
    logic [3:0][4:0] gd = '0;
    logic [3:0][4:0] ad = '0;
    int lat;
    ad[1] = 5'd4;
    run_request(1'b0, 1'b1, 24'h0, 24'h00abcd, 24'h001234, gd, ad, 0, 1'b1, 1'b0, lat);
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("[TB] FAIL wrong_id_latency got=%0d exp=11", lat);
    end
  endtask

  task automatic test_complete_hold();
    logic [3:0][4:0] gd = '0;
    logic [3:0][4:0] ad = '0;
    int lat;
    run_request(1'b1, 1'b1, 24'h000777, 24'h000888, 24'h000999, gd, ad, 20, 1'b0, 1'b1, lat);
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    w = exp_word(3, 1'b1, 24'h0, 24'h000100, 24'h000500);
    req_valid = 1'b1;
    req_data  = {1'b0, 1'b1, 24'h0, 24'h000100, 24'h000500};
    @(negedge clk); req_valid = 1'b0; arb_grant = 1'b1;
    @(negedge clk); arb_grant = 1'b0; ack_in = {1'b1, MEM};
    @(negedge clk); ack_in = 3'b000; arb_grant = 1'b1;
    @(negedge clk); arb_grant = 1'b0; ack_in = {1'b1, ACCEL};
    @(negedge clk); ack_in = 3'b000; arb_grant = 1'b1;
    @(negedge clk); arb_grant = 1'b0;
    checks++;
    if (arb_req !== 1'b0 || data_out !== w || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_wait arb=%0b data=%08h busy=%0b exp 0/%08h/1",
               arb_req, data_out, busy, w);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ready_req_out !== 1'b1 || busy !== 1'b0 || arb_req !== 1'b0 || data_out !== '0
        || valid_compq_out !== 1'b0 || compq_data_out !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset ready=%0b busy=%0b arb=%0b data=%08h valid=%0b cq=%07h exp 1/0/0/0/0/0",
               ready_req_out, busy, arb_req, data_out, valid_compq_out, compq_data_out);
    end
    ack_in = {1'b1, MEM};
    @(negedge clk);
    rst_n  = 1'b1;
    @(negedge clk);
    ack_in = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (valid_compq_out !== 1'b0 || ready_req_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL after_reset i=%0d valid=%0b ready=%0b exp 0/1", i, valid_compq_out, ready_req_out);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [3:0][4:0] gd;
    logic [3:0][4:0] ad;
    logic km;
    logic [23:0] da;
    int lat, r, exp_lat;
    for (int i = 0; i < n; i++) begin
      km = 1'($urandom);
      da = 24'($urandom);
      for (int p = 0; p < 4; p++) begin
        gd[p] = 5'($urandom_range(0, 3));
        r = $urandom_range(0, 11);
        ad[p] = (r == 0) ? 5'd15 : (r == 1) ? 5'd14 : 5'($urandom_range(0, 4));
      end
      exp_lat = model_latency(km, gd, ad);
      run_request(km, 1'($urandom), 24'($urandom), 24'($urandom), da, gd, ad,
                  $urandom_range(0, 3), 1'($urandom), 1'($urandom), lat);
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("[TB] FAIL rand_latency i=%0d err=%0b got=%0d exp=%0d",
                 i, model_err(km, ad), lat, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_min_no_key();
    test_min_key();
    test_timeout_op();
    test_wrong_id();
    test_complete_hold();
    test_reset_mid();
    test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
